// File: rtl/ram_dual_write_ctrl.sv
// ram_dual_write_ctrl: write-side frame controller for the ram_dual RAM.
// Packs a delimited byte stream into a circular buffer of 2^ADDR_WIDTH
// entries, drops frame tails beyond MAX_FRAME, tracks free space via
// credits returned by the read side and hands one descriptor per frame
// to the read-side sequencer.
module ram_dual_write_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int MAX_FRAME  = 32
) (
  input  logic                  write_clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic                  we,
  input  logic                  release_en,
  input  logic [ADDR_WIDTH:0]   release_len,
  output logic                  desc_valid,
  input  logic                  desc_ready,
  output logic [ADDR_WIDTH-1:0] desc_start,
  output logic [ADDR_WIDTH:0]   desc_len,
  output logic                  desc_trunc,
  output logic [ADDR_WIDTH:0]   free_count,
  output logic                  release_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;  // counts 0..DEPTH
  localparam int SW    = ADDR_WIDTH + 2;  // credit sum headroom

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;
  localparam logic [CW-1:0]         COUNT_ONE = 1;
  localparam logic [CW-1:0]         COUNT_MAX = CW'(MAX_FRAME);
  localparam logic [CW-1:0]         FREE_FULL = CW'(DEPTH);
  localparam logic [SW-1:0]         SUM_FULL  = SW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DROP,
    DESC
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] wptr;
  logic [CW-1:0]         count;      // bytes written for the current frame

  logic                  accept;
  logic                  write_accept;
  logic [CW-1:0]         count_inc;
  logic                  at_max;
  logic [SW-1:0]         free_sum;
  logic                  free_ovf;

  // Ready depends only on state and credits; held low during reset.
  always_comb begin
    // NOTE: default first so every path assigns in_ready and no latch is inferred.
    in_ready = 1'b0;
    if (!reset) begin
      case (state)
        IDLE, FILL: in_ready = (free_count != '0);
        DROP:       in_ready = 1'b1;
        default:    in_ready = 1'b0;
      endcase
    end
  end

  // Accept qualification, byte counting and credit arithmetic.
  always_comb begin
    accept       = in_valid && in_ready;
    write_accept = accept && ((state == IDLE) || (state == FILL));
    count_inc    = count + COUNT_ONE;
    at_max       = (count_inc == COUNT_MAX);
    free_sum     = {1'b0, free_count}
                 - {{(SW-1){1'b0}}, write_accept}
                 + (release_en ? {1'b0, release_len} : '0);
    free_ovf     = (free_sum > SUM_FULL);
  end

  // RAM write port and write pointer: one registered write per writing accept.
  always_ff @(posedge write_clock) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers
      // sample their inputs from the same pre-edge values.
      we         <= 1'b0;
      data       <= '0;
      write_addr <= '0;
      wptr       <= '0;
    end else begin
      we <= write_accept;
      if (write_accept) begin
        data       <= in_data;
        write_addr <= wptr;
        wptr       <= wptr + ADDR_ONE;  // wraps modulo the buffer depth
      end
    end
  end

  // Free-space credits: writes consume, releases return, overflow saturates.
  always_ff @(posedge write_clock) begin
    if (reset) begin
      free_count  <= FREE_FULL;
      release_err <= 1'b0;
    end else if (free_ovf) begin
      free_count  <= FREE_FULL;
      release_err <= 1'b1;
    end else begin
      free_count  <= free_sum[CW-1:0];
    end
  end

  // Frame state machine with registered descriptor outputs.
  always_ff @(posedge write_clock) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      desc_valid <= 1'b0;
      desc_start <= '0;
      desc_len   <= '0;
      desc_trunc <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            desc_start <= wptr;
            count      <= count_inc;
            if (in_last) begin
              state      <= DESC;
              desc_valid <= 1'b1;
              desc_len   <= count_inc;
              desc_trunc <= 1'b0;
            end else if (at_max) begin
              state <= DROP;
            end else begin
              state <= FILL;
            end
          end
        end

        FILL: begin
          if (accept) begin
            count <= count_inc;
            if (in_last) begin
              // Last byte landing exactly on MAX_FRAME is not a truncation.
              state      <= DESC;
              desc_valid <= 1'b1;
              desc_len   <= count_inc;
              desc_trunc <= 1'b0;
            end else if (at_max) begin
              state <= DROP;
            end
          end
        end

        DROP: begin
          // Bytes are consumed without writing; count stays at MAX_FRAME.
          if (accept && in_last) begin
            state      <= DESC;
            desc_valid <= 1'b1;
            desc_len   <= count;
            desc_trunc <= 1'b1;
          end
        end

        DESC: begin
          // Descriptor fields hold until the consumer takes them.
          if (desc_ready) begin
            state      <= IDLE;
            desc_valid <= 1'b0;
            desc_trunc <= 1'b0;
            count      <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
